// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM arbiter block.
package vram_pkg;

  // Default frame-store geometry: 32 KB, byte wide.
  localparam int VRAM_AW = 15;
  localparam int VRAM_DW = 8;

  // Cycles from a fetch_req pulse to the matching fetch_valid pulse.
  localparam int FETCH_LATENCY = 3;

  // Command that the arbiter has registered onto the RAM port this cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO used as the host write buffer.
// DEPTH must be a power of two so the pointers wrap on natural overflow.
module sync_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == LW'(DEPTH));
  assign level    = count;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage array: written on push only.
  // NOTE: the data array has no reset; occupancy is tracked by the pointers
  // and count, so clearing those is enough and keeps the array plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop hold count.
  // NOTE: sequential state uses non-blocking assignment so every flop sees
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Occupancy can never exceed the storage size.
  assert property (@(posedge clk) disable iff (reset) count <= LW'(DEPTH));

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates a single-port synchronous VRAM between a fixed-latency video
// fetch port and a host port with posted writes and blocking reads.
// Priority each cycle: video fetch, then oldest buffered write, then the
// pending host read.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW    = VRAM_AW,
  parameter int DW    = VRAM_DW,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  // Video fetch port
  input  logic                   fetch_req,
  input  logic [AW-1:0]          fetch_addr,
  output logic                   fetch_valid,
  output logic [DW-1:0]          fetch_data,
  // Host port
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic                   host_we,
  input  logic [AW-1:0]          host_addr,
  input  logic [DW-1:0]          host_wdata,
  output logic                   host_rvalid,
  output logic [DW-1:0]          host_rdata,
  // RAM command port
  output logic [AW-1:0]          ram_addr,
  output logic                   ram_we,
  output logic [DW-1:0]          ram_wdata,
  input  logic [DW-1:0]          ram_rdata,
  // Write buffer occupancy
  output logic [$clog2(DEPTH):0] wr_level
);

  localparam int EW = AW + DW;
  localparam int TW = FETCH_LATENCY - 1;

  arb_state_t     state;
  arb_state_t     state_next;

  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_empty;
  logic           fifo_full;
  logic [EW-1:0]  fifo_head;

  logic           rd_accept;
  logic           rd_pend;
  logic           rd_issued;
  logic [AW-1:0]  rd_addr;

  logic [AW-1:0]  cmd_addr;
  logic           cmd_we;
  logic [DW-1:0]  cmd_wdata;

  // Return-path tags: bit 0 marks the cycle the RAM data is valid, the top
  // bit is the outgoing valid pulse.
  logic [TW-1:0]  vid_tag;
  logic [TW-1:0]  host_tag;

  // Writes need buffer space; reads need an empty buffer (read-after-write
  // ordering) and no read already in flight. Nothing is accepted in reset.
  assign host_ready = !reset && (host_we ? !fifo_full : (fifo_empty && !rd_pend));
  assign fifo_push  = host_valid && host_ready && host_we;
  assign rd_accept  = host_valid && host_ready && !host_we;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({host_addr, host_wdata}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (wr_level)
  );

  // Pick the command for next cycle by fixed priority.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = ST_IDLE;
    fifo_pop   = 1'b0;
    cmd_addr   = '0;
    cmd_we     = 1'b0;
    cmd_wdata  = '0;
    if (fetch_req) begin
      state_next = ST_VID;
      cmd_addr   = fetch_addr;
    end else if (!fifo_empty) begin
      state_next = ST_WR;
      fifo_pop   = 1'b1;
      cmd_addr   = fifo_head[EW-1:DW];
      cmd_we     = 1'b1;
      cmd_wdata  = fifo_head[DW-1:0];
    end else if (rd_pend && !rd_issued) begin
      state_next = ST_RD;
      cmd_addr   = rd_addr;
    end else if (rd_accept) begin
      // A read accepted on an otherwise idle bus issues straight away.
      state_next = ST_RD;
      cmd_addr   = host_addr;
    end
  end

  // Register the chosen command onto the RAM port together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      state     <= state_next;
      ram_addr  <= cmd_addr;
      ram_we    <= cmd_we;
      ram_wdata <= cmd_wdata;
    end
  end

  // Track the single outstanding host read from acceptance to host_rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend   <= 1'b0;
      rd_issued <= 1'b0;
      rd_addr   <= '0;
    end else begin
      if (rd_accept) begin
        rd_pend <= 1'b1;
        rd_addr <= host_addr;
      end
      if (state_next == ST_RD) begin
        rd_issued <= 1'b1;
      end
      // This edge raises host_rvalid, which retires the read.
      if (host_tag[0]) begin
        rd_pend   <= 1'b0;
        rd_issued <= 1'b0;
      end
    end
  end

  // Follow each read command down the RAM pipeline and capture its data.
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_tag    <= '0;
      host_tag   <= '0;
      fetch_data <= '0;
      host_rdata <= '0;
    end else begin
      vid_tag  <= {vid_tag[TW-2:0], state == ST_VID};
      host_tag <= {host_tag[TW-2:0], state == ST_RD};
      if (vid_tag[0]) begin
        fetch_data <= ram_rdata;
      end
      if (host_tag[0]) begin
        host_rdata <= ram_rdata;
      end
    end
  end

  assign fetch_valid = vid_tag[TW-1];
  assign host_rvalid = host_tag[TW-1];

  // host_ready already blocks a push into a full buffer.
  assert property (@(posedge clk) disable iff (reset) !(fifo_push && fifo_full));

  // A fetch command must never be displaced by host traffic.
  assert property (@(posedge clk) disable iff (reset) fetch_req |=> (state == ST_VID));

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized
// host/video traffic scored against a transaction-level model.
module tb_vram_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          host_valid = 1'b0;
  logic          host_ready;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [LW-1:0] wr_level;

  vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .wr_level    (wr_level)
  );

  always #5 clk = ~clk;

  // Physical single-port synchronous RAM owned by the bench.
  logic [DW-1:0] mem      [1 << AW];
  // Host's view of memory: every accepted host write applied in order.
  logic [DW-1:0] host_mem [1 << AW];

  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int            cmd_cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } fetch_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  fetch_t        fq[$];
  wr_t           wq[$];
  logic [DW-1:0] rq[$];

  always @(negedge clk) begin : monitor
    bit  vid_cmd;
    bit  exp_fv;
    wr_t w;
    if (reset) begin
      fq.delete();
      wq.delete();
      rq.delete();
    end else begin
      // RAM command: a fetch owns the cycle after its request; otherwise any
      // write must be the oldest accepted host write.
      vid_cmd = 1'b0;
      foreach (fq[i]) begin
        if (fq[i].cmd_cyc == cyc) begin
          vid_cmd = 1'b1;
          check("vid_cmd_we", ram_we, 0);
          check("vid_cmd_addr", ram_addr, fq[i].addr);
          fq[i].data = mem[fq[i].addr];
        end
      end
      if (!vid_cmd && ram_we) begin
        if (wq.size() == 0) begin
          check("ram_we_unexpected", ram_we, 0);
        end else begin
          w = wq.pop_front();
          check("drain_addr", ram_addr, w.addr);
          check("drain_data", ram_wdata, w.data);
        end
      end
      // Fetch return exactly two cycles after its command.
      exp_fv = (fq.size() > 0) && (fq[0].cmd_cyc + 2 == cyc);
      check("fetch_valid", fetch_valid, exp_fv);
      if (exp_fv) begin
        check("fetch_data", fetch_data, fq[0].data);
        void'(fq.pop_front());
      end
      // Host read return.
      if (host_rvalid) begin
        if (rq.size() == 0) check("host_rvalid_spurious", host_rvalid, 0);
        else check("host_rdata", host_rdata, rq.pop_front());
      end
      // Record new requests seen this cycle.
      if (fetch_req) fq.push_back('{cyc + 1, fetch_addr, '0});
      if (host_valid && host_ready) begin
        if (host_we) begin
          wq.push_back('{host_addr, host_wdata});
          host_mem[host_addr] = host_wdata;
        end else begin
          rq.push_back(host_mem[host_addr]);
        end
      end
    end
  end

  // One blocking host transaction with bounded waits.
  task automatic host_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    tick();
    host_valid = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    n = 0;
    mid();
    while (!host_ready && n < 64) begin
      n++;
      mid();
    end
    if (!host_ready) check("host_ready_timeout", host_ready, 1);
    tick();
    host_valid = 1'b0;
    if (!we) begin
      n = 0;
      mid();
      while (!host_rvalid && n < 64) begin
        n++;
        mid();
      end
      if (!host_rvalid) check("host_rvalid_timeout", host_rvalid, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 7 + 3);
    mem[15'h1234] = 8'h3C;
    for (int i = 0; i < (1 << AW); i++) host_mem[i] = mem[i];

    // ---- reset state, host_ready low while in reset ----
    repeat (2) tick();
    host_valid = 1'b1; host_we = 1'b1; host_addr = 15'h7; host_wdata = 8'h1;
    mid();
    check("rst_host_ready", host_ready, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_data", fetch_data, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_wr_level", wr_level, 0);
    tick();
    reset = 1'b0; host_valid = 1'b0;
    repeat (2) tick();

    // ---- single posted write on idle bus ----
    host_valid = 1'b1; host_we = 1'b1; host_addr = 15'h0010; host_wdata = 8'hA5;
    mid();
    check("w1_ready", host_ready, 1);
    tick(); host_valid = 1'b0;
    mid();
    check("w1_level_1", wr_level, 1);
    check("w1_no_we_yet", ram_we, 0);
    tick(); mid();
    check("w1_we", ram_we, 1);
    check("w1_addr", ram_addr, 15'h0010);
    check("w1_wdata", ram_wdata, 8'hA5);
    check("w1_level_0", wr_level, 0);

    // ---- fetch latency ----
    tick(); fetch_req = 1'b1; fetch_addr = 15'h1234;
    tick(); fetch_req = 1'b0;
    mid(); check("f_t1_valid", fetch_valid, 0);
    tick(); mid(); check("f_t2_valid", fetch_valid, 0);
    tick(); mid();
    check("f_t3_valid", fetch_valid, 1);
    check("f_t3_data", fetch_data, 8'h3C);
    tick(); mid(); check("f_t4_valid", fetch_valid, 0);

    // ---- four writes under continuous fetch ----
    tick();
    for (int c = 0; c < 6; c++) begin
      fetch_req  = 1'b1;
      fetch_addr = AW'(16'h0100 + c);
      host_valid = (c < 5);
      host_we    = 1'b1;
      host_addr  = AW'(16'h0200 + c);
      host_wdata = DW'(8'h10 + c);
      mid();
      check("burst_no_we", ram_we, 0);
      if (c < 4) check("burst_ready", host_ready, 1);
      if (c == 4) begin
        check("burst_full_ready", host_ready, 0);
        check("burst_full_level", wr_level, 4);
      end
      tick();
    end
    fetch_req = 1'b0; host_valid = 1'b0;
    mid();
    check("burst_last_fetch_no_we", ram_we, 0);
    check("burst_level_4", wr_level, 4);
    for (int k = 0; k < 4; k++) begin
      tick(); mid();
      check("burst_drain_we", ram_we, 1);
      check("burst_drain_addr", ram_addr, 16'h0200 + k);
      check("burst_drain_data", ram_wdata, 8'h10 + k);
    end

    // ---- read after write ----
    tick(); host_valid = 1'b1; host_we = 1'b1; host_addr = 15'h0020; host_wdata = 8'h55;
    mid(); check("raw_wr_ready", host_ready, 1);
    tick(); host_we = 1'b0;
    mid(); check("raw_rd_blocked", host_ready, 0);
    tick(); mid(); check("raw_rd_ready", host_ready, 1);
    tick(); host_valid = 1'b0;
    mid(); check("raw_r1_rvalid", host_rvalid, 0);
    tick(); mid(); check("raw_r2_rvalid", host_rvalid, 0);
    tick(); mid();
    check("raw_r3_rvalid", host_rvalid, 1);
    check("raw_r3_rdata", host_rdata, 8'h55);

    // ---- fetch and host read in the same cycle ----
    tick();
    fetch_req = 1'b1; fetch_addr = 15'h1234;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 15'h0020;
    mid(); check("coll_rd_ready", host_ready, 1);
    tick(); fetch_req = 1'b0; host_valid = 1'b0;
    tick(); tick(); mid();
    check("coll_r3_rvalid", host_rvalid, 0);
    check("coll_r3_fetch_valid", fetch_valid, 1);
    tick(); mid();
    check("coll_r4_rvalid", host_rvalid, 1);
    check("coll_r4_rdata", host_rdata, 8'h55);

    // ---- randomized mixed traffic ----
    fork
      begin
        for (int c = 0; c < 1200; c++) begin
          tick();
          fetch_req  = (c % 8 == 0) || ($urandom_range(0, 9) == 0);
          fetch_addr = AW'($urandom_range(0, 127));
        end
        tick();
        fetch_req = 1'b0;
      end
      begin
        for (int t = 0; t < 150; t++) begin
          repeat ($urandom_range(0, 2)) tick();
          host_txn($urandom_range(0, 3) != 0, AW'($urandom_range(0, 127)), DW'($urandom));
        end
      end
    join
    repeat (10) tick();
    mid();
    check("end_wr_level", wr_level, 0);
    check("end_wq_empty", wq.size(), 0);
    check("end_rq_empty", rq.size(), 0);
    check("end_fq_empty", fq.size(), 0);

    // ---- reset with buffered writes and a pending read ----
    tick();
    fetch_req = 1'b1; fetch_addr = 15'h0040;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 15'h0030;
    mid(); check("mr_rd_ready", host_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      host_we = 1'b1; host_addr = AW'(16'h0300 + k); host_wdata = DW'(k + 1);
      mid(); check("mr_wr_ready", host_ready, 1);
    end
    tick();
    fetch_req = 1'b0; host_valid = 1'b0; reset = 1'b1;
    mid(); check("mr_level_3", wr_level, 3);
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mid();
      check("mr_wr_level", wr_level, 0);
      check("mr_ram_we", ram_we, 0);
      check("mr_host_rvalid", host_rvalid, 0);
      check("mr_fetch_valid", fetch_valid, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
